// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// debounce_pkg -- per-channel state encoding and 100 MHz default timing
// Rev 1.0
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    DB_LOW      = 2'd0,
    DB_CHK_HIGH = 2'd1,
    DB_HIGH     = 2'd2,
    DB_CHK_LOW  = 2'd3
  } db_state_t;

  localparam int DB_SYNC_STAGES  = 2;
  localparam int DB_STABLE_10MS  = 1_000_000;
  localparam int DB_REPEAT_250MS = 25_000_000;

endpackage
`default_nettype wire

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// button_debouncer_if -- raw/debounced button bundle; btn_rep with DEBOUNCE_REPEAT_EN
// Rev 1.0
// ============================================================================
interface button_debouncer_if #(
  parameter int NUM_BTN = 5
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_chg;
`ifdef DEBOUNCE_REPEAT_EN
  logic [NUM_BTN-1:0] btn_rep;
`endif

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_chg
`ifdef DEBOUNCE_REPEAT_EN
    , input btn_rep
`endif
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_chg
`ifdef DEBOUNCE_REPEAT_EN
    , output btn_rep
`endif
  );

endinterface
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// debounce_channel -- one-bit synchroniser, qualification FSM, optional auto-repeat
// Rev 1.0 -- auto-repeat built only with DEBOUNCE_REPEAT_EN
// ============================================================================
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DB_STABLE_10MS
`ifdef DEBOUNCE_REPEAT_EN
  , parameter int REPEAT_CYCLES = DB_REPEAT_250MS
`endif
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_raw,
  output logic      o_db,
  output logic      o_chg
`ifdef DEBOUNCE_REPEAT_EN
  , output logic    o_rep
`endif
);

  localparam int              CNT_W      = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_t              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   r_db;
  logic                   r_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Any sample that disagrees with the candidate level drops back to the stable state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DB_LOW;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      case (r_state)
        DB_LOW: begin
          if (w_s) begin
            r_state <= DB_CHK_HIGH;
            r_cnt   <= c_CNT_ONE;
          end
        end
        DB_CHK_HIGH: begin
          if (!w_s) begin
            r_state <= DB_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state <= DB_HIGH;
            r_cnt   <= '0;
            r_db    <= 1'b1;
            r_chg   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DB_HIGH: begin
          if (!w_s) begin
            r_state <= DB_CHK_LOW;
            r_cnt   <= c_CNT_ONE;
          end
        end
        DB_CHK_LOW: begin
          if (w_s) begin
            r_state <= DB_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state <= DB_LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_chg   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= DB_LOW;
          r_cnt   <= '0;
          r_db    <= 1'b0;
        end
      endcase
    end
  end

  assign o_db  = r_db;
  assign o_chg = r_chg;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int               REP_W      = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] c_REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep;
  logic             w_held;
  logic             w_fall_accept;

  assign w_held        = (r_state == DB_HIGH) || (r_state == DB_CHK_LOW);
  assign w_fall_accept = (r_state == DB_CHK_LOW) && !w_s && (r_cnt == c_CNT_LAST);

  // Counter is zero on the accept edge into HIGH, so the first strobe lands REPEAT_CYCLES later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
      r_rep     <= 1'b0;
    end else if (!w_held || w_fall_accept) begin
      r_rep_cnt <= '0;
      r_rep     <= 1'b0;
    end else if (r_rep_cnt == c_REP_LAST) begin
      r_rep_cnt <= '0;
      r_rep     <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
      r_rep     <= 1'b0;
    end
  end

  assign o_rep = r_rep;
`endif

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// button_debouncer -- NUM_BTN independent debounce channels; DEBOUNCE_REPEAT_EN adds btn_rep
// Rev 1.0
// ============================================================================
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_BTN       = 5,
  parameter int SYNC_STAGES   = DB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DB_STABLE_10MS
`ifdef DEBOUNCE_REPEAT_EN
  , parameter int REPEAT_CYCLES = DB_REPEAT_250MS
`endif
) (
  input wire logic          clk,
  input wire logic          rst_n,
  button_debouncer_if.slave bus
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
`ifdef DEBOUNCE_REPEAT_EN
      , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .i_raw (bus.btn_raw[i]),
      .o_db  (bus.btn_db[i]),
      .o_chg (bus.btn_chg[i])
`ifdef DEBOUNCE_REPEAT_EN
      , .o_rep (bus.btn_rep[i])
`endif
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// tb_button_debouncer -- directed scenarios plus random presses against a cycle-level model.
// Build with DEBOUNCE_REPEAT_EN defined to exercise btn_rep.
module tb_button_debouncer;

  localparam int N      = 5;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int REPEAT = 8;
  localparam int RISE_N = SYNC + STABLE;  // tick index (first sampling edge = 1) of the accept

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  button_debouncer_if #(.NUM_BTN(N)) bus ();

  button_debouncer #(
    .NUM_BTN       (N),
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
`ifdef DEBOUNCE_REPEAT_EN
    , .REPEAT_CYCLES (REPEAT)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the level flips after STABLE consecutive disagreeing samples, each
  // sample being the raw level from SYNC edges earlier; repeats fire every REPEAT cycles
  // after the rise while the level stays high.
  logic [N-1:0] m_pipe [SYNC];
  logic [N-1:0] m_db, m_chg, m_rep;
  int           m_run  [N];
  int           m_rise [N];
  int           t = 0;

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_pipe[j] = '0;
    m_db = '0; m_chg = '0; m_rep = '0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_rise[i] = 0; end
  endtask

  task automatic tick();
    logic [N-1:0] x;
    @(posedge clk);
    t++;
    x = m_pipe[SYNC-1];
    for (int j = SYNC-1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
    m_pipe[0] = bus.btn_raw;
    for (int i = 0; i < N; i++) begin
      logic was;
      was      = m_db[i];
      m_chg[i] = 1'b0;
      m_rep[i] = 1'b0;
      if (x[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == STABLE) begin
          m_db[i]  = ~m_db[i];
          m_chg[i] = 1'b1;
          m_run[i] = 0;
          if (m_db[i]) m_rise[i] = t;
        end
      end else begin
        m_run[i] = 0;
      end
`ifdef DEBOUNCE_REPEAT_EN
      if (was && m_db[i] && ((t - m_rise[i]) % REPEAT == 0)) m_rep[i] = 1'b1;
`else
      if (was && !m_db[i]) m_rep[i] = 1'b0;
`endif
    end
    #1;
  endtask

  function automatic logic [3*N-1:0] dut_vec();
`ifdef DEBOUNCE_REPEAT_EN
    return {bus.btn_rep, bus.btn_chg, bus.btn_db};
`else
    return {{N{1'b0}}, bus.btn_chg, bus.btn_db};
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.btn_raw = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_cnt++;
    if (dut_vec() !== '0) $display("FAIL reset_outputs got=%h want=0", dut_vec());
    else pass_cnt++;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_cnt++;
      if (dut_vec() !== {m_rep, m_chg, m_db})
        $display("FAIL reset_idle t=%0d got=%h want=%h", t, dut_vec(), {m_rep, m_chg, m_db});
      else pass_cnt++;
    end
  endtask

  task automatic test_single_press();
    do_reset();
    bus.btn_raw = 5'b00001;
    for (int n = 1; n <= RISE_N + 2; n++) begin
      tick();
      chk_cnt++;
      if (bus.btn_db !== ((n >= RISE_N) ? 5'b00001 : 5'b00000) ||
          bus.btn_chg !== ((n == RISE_N) ? 5'b00001 : 5'b00000))
        $display("FAIL single_press n=%0d db=%b chg=%b want_rise_at=%0d", n, bus.btn_db, bus.btn_chg, RISE_N);
      else pass_cnt++;
      chk_cnt++;
      if (dut_vec() !== {m_rep, m_chg, m_db})
        $display("FAIL single_model t=%0d got=%h want=%h", t, dut_vec(), {m_rep, m_chg, m_db});
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   bounce_chg = 0;
    int   rise_n = -1;
    int   rises = 0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      bus.btn_raw[1] = pat[p];
      tick();
      if (bus.btn_chg[1]) bounce_chg++;
    end
    bus.btn_raw[1] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bus.btn_chg[1]) begin rises++; rise_n = n; end
      chk_cnt++;
      if (dut_vec() !== {m_rep, m_chg, m_db})
        $display("FAIL bounce_model t=%0d got=%h want=%h", t, dut_vec(), {m_rep, m_chg, m_db});
      else pass_cnt++;
    end
    chk_cnt++;
    if (bounce_chg != 0 || rises != 1 || rise_n != RISE_N || bus.btn_db[1] !== 1'b1)
      $display("FAIL bounce chg_in_bounce=%0d rises=%0d rise_at=%0d want 0/1/%0d", bounce_chg, rises, rise_n, RISE_N);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int bad = 0;
    do_reset();
    bus.btn_raw[2] = 1'b1;
    repeat (RISE_N + 2) tick();
    chk_cnt++;
    if (bus.btn_db[2] !== 1'b1) $display("FAIL glitch_setup db2=%b want=1", bus.btn_db[2]);
    else pass_cnt++;
    for (int n = 0; n < 15; n++) begin
      bus.btn_raw[2] = (n < STABLE - 1) ? 1'b0 : 1'b1;
      tick();
      if (bus.btn_db[2] !== 1'b1 || bus.btn_chg[2] !== 1'b0) bad++;
      chk_cnt++;
      if (dut_vec() !== {m_rep, m_chg, m_db})
        $display("FAIL glitch_model t=%0d got=%h want=%h", t, dut_vec(), {m_rep, m_chg, m_db});
      else pass_cnt++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL glitch_hold bad_cycles=%0d want=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.btn_raw[3] = 1'b1;
    repeat (SYNC + 2) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_cnt++;
    if (bus.btn_db !== '0 || bus.btn_chg !== '0)
      $display("FAIL reset_mid_async db=%b chg=%b want=0", bus.btn_db, bus.btn_chg);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 1; n <= RISE_N + 2; n++) begin
      tick();
      chk_cnt++;
      if (bus.btn_db[3] !== ((n >= RISE_N) ? 1'b1 : 1'b0))
        $display("FAIL reset_mid_requal n=%0d db3=%b want_rise_at=%0d", n, bus.btn_db[3], RISE_N);
      else pass_cnt++;
    end
  endtask

  task automatic test_two_channels();
    int c0 = 0;
    int c4 = 0;
    do_reset();
    bus.btn_raw = 5'b10001;
    for (int n = 0; n < 40; n++) begin
      if (n == 20) bus.btn_raw[0] = 1'b0;
      tick();
      if (bus.btn_chg[0]) c0++;
      if (bus.btn_chg[4]) c4++;
      chk_cnt++;
      if (dut_vec() !== {m_rep, m_chg, m_db})
        $display("FAIL two_ch_model t=%0d got=%h want=%h", t, dut_vec(), {m_rep, m_chg, m_db});
      else pass_cnt++;
    end
    chk_cnt++;
    if (c0 != 2 || c4 != 1 || bus.btn_db !== 5'b10000)
      $display("FAIL two_ch chg0=%0d chg4=%0d db=%b want 2/1/10000", c0, c4, bus.btn_db);
    else pass_cnt++;
  endtask

`ifdef DEBOUNCE_REPEAT_EN
  task automatic test_repeat();
    logic seen = 1'b0;
    logic fallen = 1'b0;
    int   late = 0;
    do_reset();
    bus.btn_raw[1] = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = bus.btn_chg[1];
    end
    chk_cnt++;
    if (!seen) $display("FAIL repeat_accept no btn_chg[1] within 20 cycles");
    else pass_cnt++;
    for (int n = 1; n <= 30; n++) begin
      tick();
      chk_cnt++;
      if (bus.btn_rep[1] !== ((n % REPEAT) == 0))
        $display("FAIL repeat_pulse n=%0d rep1=%b want=%b", n, bus.btn_rep[1], (n % REPEAT) == 0);
      else pass_cnt++;
    end
    bus.btn_raw[1] = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus.btn_db[1] === 1'b0) fallen = 1'b1;
      if (fallen && bus.btn_rep[1] !== 1'b0) late++;
      chk_cnt++;
      if (dut_vec() !== {m_rep, m_chg, m_db})
        $display("FAIL repeat_model t=%0d got=%h want=%h", t, dut_vec(), {m_rep, m_chg, m_db});
      else pass_cnt++;
    end
    chk_cnt++;
    if (!fallen || late != 0) $display("FAIL repeat_stop fallen=%b late_pulses=%0d want 1/0", fallen, late);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    do_reset();
    bus.btn_raw = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 6) == 0) bus.btn_raw[i] = ~bus.btn_raw[i];
      tick();
      chk_cnt++;
      if (dut_vec() !== {m_rep, m_chg, m_db})
        $display("FAIL random_model t=%0d got=%h want=%h", t, dut_vec(), {m_rep, m_chg, m_db});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_two_channels();
`ifdef DEBOUNCE_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
